// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Provides the FSM state encoding, the zero-register index, the default
// multi-cycle latency, the control-output bundle and a load-use helper.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W         = 5;
    localparam int unsigned MC_CYCLES_DEF = 4;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // FSM state encoding
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MC_BUSY = 1'b1;

    // Control outputs toward the pipeline registers
    typedef struct packed {
        logic pc_write;
        logic if2id_write;
        logic if2id_flush;
        logic id2exe_bubble;
        logic id2exe_hold;
        logic mc_busy;
        logic mc_done;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        pc_write:      1'b1,
        if2id_write:   1'b1,
        if2id_flush:   1'b0,
        id2exe_bubble: 1'b0,
        id2exe_hold:   1'b0,
        mc_busy:       1'b0,
        mc_done:       1'b0
    };

    // A load in EXE targets a register the ID instruction reads
    function automatic logic load_use(
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             id_uses_rs,
        input logic             id_uses_rt,
        input logic             exe_mem_read,
        input logic [REG_W-1:0] exe_rt
    );
        return exe_mem_read && (exe_rt != REG_ZERO) &&
               ((id_uses_rs && (id_rs == exe_rt)) ||
                (id_uses_rt && (id_rt == exe_rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bus between the pipeline datapath/decoder and the hazard/stall controller.
// master: pipeline side (drives hazard inputs, consumes enables/controls).
// slave:  controller side (consumes hazard inputs, drives enables/controls).
interface hazard_stall_ctrl_if #(
    parameter int unsigned STAT_W = 16
);
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              exe_mem_read;
    logic [REG_W-1:0]  exe_rt;
    logic              exe_mc_start;
    logic              branch_taken;
    logic              stat_clr;

    logic              pc_write;
    logic              if2id_write;
    logic              if2id_flush;
    logic              id2exe_bubble;
    logic              id2exe_hold;
    logic              mc_busy;
    logic              mc_done;
    logic [STAT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, exe_mem_read, exe_rt,
               exe_mc_start, branch_taken, stat_clr,
        input  pc_write, if2id_write, if2id_flush, id2exe_bubble, id2exe_hold,
               mc_busy, mc_done, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, exe_mem_read, exe_rt,
               exe_mc_start, branch_taken, stat_clr,
        output pc_write, if2id_write, if2id_flush, id2exe_bubble, id2exe_hold,
               mc_busy, mc_done, stall_cycles
    );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Ports: clk, rst (sync active-low), inc, clr, count[W-1:0].
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, else increment until all-ones
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the ID/EXE boundary.
// Inserts a bubble on load-use, flushes IF/ID on a taken branch and holds
// EXE for MC_CYCLES cycles during a multi-cycle ALU op; counts stall cycles.
// Ports: clk, rst (sync active-low), bus (slave modport: hazard inputs in,
// PC/IF-ID/ID-EXE controls, mc_busy/mc_done and stall_cycles out).
// Control outputs are combinational from state and inputs.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_CYCLES = MC_CYCLES_DEF,
    parameter int unsigned STAT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (MC_CYCLES > 2) ? $clog2(MC_CYCLES) : 1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    ctrl_t            ctrl;
    logic             lu;

    assign lu = load_use(bus.id_rs, bus.id_rt, bus.id_uses_rs, bus.id_uses_rt,
                         bus.exe_mem_read, bus.exe_rt);

    // Next-state and control outputs; reset forces default controls
    always_comb begin
        ctrl    = CTRL_DEFAULT;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst) begin
            if (state_q == ST_MC_BUSY) begin
                ctrl.mc_busy = 1'b1;
                if (cnt_q != '0) begin
                    ctrl.pc_write    = 1'b0;
                    ctrl.if2id_write = 1'b0;
                    ctrl.id2exe_hold = 1'b1;
                    cnt_d            = cnt_q - CNT_W'(1);
                end else begin
                    // Last EXE cycle of the op: release the front end
                    ctrl.mc_done = 1'b1;
                    state_d      = ST_RUN;
                end
            end else begin
                if (bus.branch_taken) begin
                    ctrl.if2id_flush   = 1'b1;
                    ctrl.id2exe_bubble = 1'b1;
                end else if (bus.exe_mc_start) begin
                    ctrl.pc_write    = 1'b0;
                    ctrl.if2id_write = 1'b0;
                    ctrl.id2exe_hold = 1'b1;
                    ctrl.mc_busy     = 1'b1;
                    state_d          = ST_MC_BUSY;
                    // First busy cycle is this one; done fires when cnt hits 0
                    cnt_d            = CNT_W'(MC_CYCLES - 2);
                end else if (lu) begin
                    ctrl.pc_write      = 1'b0;
                    ctrl.if2id_write   = 1'b0;
                    ctrl.id2exe_bubble = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(
        .W (STAT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!ctrl.pc_write),
        .clr   (bus.stat_clr),
        .count (bus.stall_cycles)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.if2id_write   = ctrl.if2id_write;
    assign bus.if2id_flush   = ctrl.if2id_flush;
    assign bus.id2exe_bubble = ctrl.id2exe_bubble;
    assign bus.id2exe_hold   = ctrl.id2exe_hold;
    assign bus.mc_busy       = ctrl.mc_busy;
    assign bus.mc_done       = ctrl.mc_done;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios then random
// traffic, checked against a cycle-level reference model.
module tb_hazard_stall_ctrl;

    localparam int unsigned MC = 4;
    localparam int unsigned SW = 4;
    localparam int          SAT_MAX = (1 << SW) - 1;

    // ctrl bit positions: {pc_write, if2id_write, flush, bubble, hold, busy, done}
    localparam int PCW = 6, IFW = 5, FL = 4, BB = 3, HD = 2, BS = 1, DN = 0;

    typedef struct packed {
        logic [6:0]    ctrl;
        logic [SW-1:0] stall;
    } exp_t;

    logic clk;
    logic rst;

    hazard_stall_ctrl_if #(.STAT_W(SW)) bus ();

    hazard_stall_ctrl #(
        .MC_CYCLES (MC),
        .STAT_W    (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_left  = 0;  // EXE cycles still owed to the multi-cycle op
    int   m_stall = 0;  // model of stall_cycles

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, push the expected response, advance the model
    task automatic cyc(input logic r,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic mr,
                       input logic [4:0] ert, input logic mcs,
                       input logic br, input logic clr);
        exp_t e;
        logic lu;
        @(posedge clk);
        #1;
        rst              = r;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_uses_rs   = urs;
        bus.id_uses_rt   = urt;
        bus.exe_mem_read = mr;
        bus.exe_rt       = ert;
        bus.exe_mc_start = mcs;
        bus.branch_taken = br;
        bus.stat_clr     = clr;

        e.ctrl      = 7'b0;
        e.ctrl[PCW] = 1'b1;
        e.ctrl[IFW] = 1'b1;
        e.stall     = SW'(m_stall);
        lu = mr && (ert != 5'd0) && ((urs && rs == ert) || (urt && rt == ert));

        if (!r) begin
            m_left  = 0;
            m_stall = 0;
        end else begin
            if (m_left > 0) begin
                e.ctrl[BS] = 1'b1;
                if (m_left == 1) begin
                    e.ctrl[DN] = 1'b1;
                end else begin
                    e.ctrl[PCW] = 1'b0;
                    e.ctrl[IFW] = 1'b0;
                    e.ctrl[HD]  = 1'b1;
                end
                m_left = m_left - 1;
            end else if (br) begin
                e.ctrl[FL] = 1'b1;
                e.ctrl[BB] = 1'b1;
            end else if (mcs) begin
                e.ctrl[PCW] = 1'b0;
                e.ctrl[IFW] = 1'b0;
                e.ctrl[HD]  = 1'b1;
                e.ctrl[BS]  = 1'b1;
                m_left = MC - 1;
            end else if (lu) begin
                e.ctrl[PCW] = 1'b0;
                e.ctrl[IFW] = 1'b0;
                e.ctrl[BB]  = 1'b1;
            end
            if (clr)
                m_stall = 0;
            else if (!e.ctrl[PCW] && m_stall < SAT_MAX)
                m_stall = m_stall + 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    // Monitor: compare DUT outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [6:0] got;
            e   = exp_q.pop_front();
            got = {bus.pc_write, bus.if2id_write, bus.if2id_flush,
                   bus.id2exe_bubble, bus.id2exe_hold, bus.mc_busy, bus.mc_done};
            total++;
            if (got !== e.ctrl) begin
                bad++;
                $display("FAIL ctrl t=%0t got=%b exp=%b", $time, got, e.ctrl);
            end
            total++;
            if (bus.stall_cycles !== e.stall) begin
                bad++;
                $display("FAIL stall_cycles t=%0t got=%0d exp=%0d",
                         $time, bus.stall_cycles, e.stall);
            end
            total++;
            if ((bus.id2exe_bubble & bus.id2exe_hold) !== 1'b0) begin
                bad++;
                $display("FAIL bubble_hold_excl t=%0t got=%b exp=0", $time,
                         bus.id2exe_bubble & bus.id2exe_hold);
            end
        end
    end

    initial begin
        rst              = 1'b0;
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_uses_rs   = 1'b0;
        bus.id_uses_rt   = 1'b0;
        bus.exe_mem_read = 1'b0;
        bus.exe_rt       = '0;
        bus.exe_mc_start = 1'b0;
        bus.branch_taken = 1'b0;
        bus.stat_clr     = 1'b0;

        // Reset with every input active
        repeat (2) cyc(1'b0, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
        repeat (2) idle();

        // Load-use on rs, then the bubble clears MemRead
        cyc(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
        // Load to r0 never stalls
        cyc(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        // Branch wins over a simultaneous load-use
        cyc(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0);
        idle();

        // Multi-cycle op; branches during busy are ignored
        cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle();

        // Reset on the second busy cycle aborts the op
        cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        idle();
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) idle();

        // Saturation, then clear beats a concurrent stall
        repeat (20) cyc(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        repeat (2) idle();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(1'($urandom_range(0, 149) != 0),
                pick_reg(), pick_reg(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), pick_reg(),
                1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 39) == 0));
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control unit that sequences the ID/EXE pipeline register and the front-end registers (PC, IF/ID).
- Detects load-use hazards and inserts one bubble into ID/EXE.
- Flushes on a taken branch resolved in EXE.
- Holds EXE for a fixed number of cycles while a multi-cycle ALU operation (mult/div) completes.
- Counts stall cycles for performance monitoring.
- Sits beside the decoder. Its outputs drive the PC enable, the IF/ID enable and flush, and the bubble/hold controls on the ID/EXE register.

Parameters:
- MC_CYCLES, 4, number of cycles a multi-cycle op occupies EXE (legal range 2..16).
- STAT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset (rst==0 resets on the clk edge).
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- exe_mem_read  in  1  MemRead of the instruction in EXE.
- exe_rt  in  5  destination rt of the instruction in EXE (load target).
- exe_mc_start  in  1  instruction in EXE is a multi-cycle ALU op.
- branch_taken  in  1  branch/jump resolved taken in EXE this cycle.
- stat_clr  in  1  synchronous clear of stall_cycles.
- pc_write  out  1  PC load enable.
- if2id_write  out  1  IF/ID load enable.
- if2id_flush  out  1  IF/ID clear to NOP.
- id2exe_bubble  out  1  ID/EXE captures all-zero controls (NOP) instead of ID outputs.
- id2exe_hold  out  1  ID/EXE keeps its current contents.
- mc_busy  out  1  multi-cycle op in progress.
- mc_done  out  1  one-cycle pulse in the last cycle of the multi-cycle op.
- stall_cycles  out  STAT_W  saturating count of cycles with pc_write==0.

Behaviour:
- State machine, two states:
  - RUN: normal flow.
  - MC_BUSY: multi-cycle op in progress. Uses a down-counter cnt, width $clog2(MC_CYCLES).
- Reset (rst==0 at the edge):
  - state=RUN, cnt=0, stall_cycles=0.
  - Outputs are combinational from state and inputs. While rst==0 they are forced to defaults: pc_write=1, if2id_write=1, all other outputs 0.
- Default outputs (no event): pc_write=1, if2id_write=1, if2id_flush=0, id2exe_bubble=0, id2exe_hold=0, mc_busy=0, mc_done=0.
- Load-use hazard definition: lu = exe_mem_read && exe_rt!=0 && ((id_uses_rs && id_rs==exe_rt) || (id_uses_rt && id_rt==exe_rt)).
- RUN priority is branch_taken > exe_mc_start > lu:
  - branch_taken: if2id_flush=1, id2exe_bubble=1, pc_write=1 (PC loads target). exe_mc_start and lu are ignored. Stay in RUN.
  - exe_mc_start: pc_write=0, if2id_write=0, id2exe_hold=1, mc_busy=1. Next state MC_BUSY with cnt=MC_CYCLES-2.
  - lu: pc_write=0, if2id_write=0, id2exe_bubble=1 for exactly one cycle. Stay in RUN. The bubble clears exe_mem_read next cycle, so the hazard self-resolves.
- MC_BUSY:
  - All hazard and branch inputs are ignored; EXE holds the multi-cycle op, so no new branch can resolve.
  - cnt!=0: pc_write=0, if2id_write=0, id2exe_hold=1, mc_busy=1, cnt decrements.
  - cnt==0: mc_done=1, mc_busy=1, hold released (default enables). Next state RUN.
- Net effect: the multi-cycle op occupies EXE for exactly MC_CYCLES cycles, and the front end stalls MC_CYCLES-1 cycles.
- id2exe_bubble and id2exe_hold are never both 1.
- stall_cycles:
  - Increments on every edge where pc_write==0.
  - Saturates at all-ones.
  - stat_clr has priority over increment: the register reads 0 after that edge.
- Reset asserted mid-operation (MC_BUSY at any cnt) aborts immediately to RUN. No mc_done pulse.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding (RUN=1'b0, MC_BUSY=1'b1);
  - REG_ZERO=5'd0;
  - default MC_CYCLES constant.
- Sub-module sat_counter (parameter W; inputs inc and clr; output count) implements stall_cycles.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all inputs active -> pc_write=1, if2id_write=1, others 0, stall_cycles=0. Release -> state RUN.
- Load-use: exe_mem_read=1, exe_rt=8, id_rs=8, id_uses_rs=1 -> exactly 1 cycle of pc_write=0 and id2exe_bubble=1, stall_cycles=1. With exe_rt=0 -> no stall.
- Branch with simultaneous lu: branch_taken=1 and lu=1 -> if2id_flush=1, id2exe_bubble=1, pc_write=1. No stall counted.
- Multi-cycle (MC_CYCLES=4): exe_mc_start pulse -> id2exe_hold=1 for 3 cycles, mc_done=1 on cycle 4, stall_cycles=3. branch_taken=1 during busy -> no flush.
- Reset mid-op: rst=0 on cycle 2 of MC_BUSY -> next cycle RUN, mc_busy=0, no mc_done.
- Saturation/clear (STAT_W=4): 20 stall cycles -> stall_cycles=15. stat_clr=1 together with a stall -> stall_cycles=0.
